// File: rtl/uart_bram_packer_pkg.sv
// Shared constants for the UART-to-BRAM byte packer: FSM encodings and lane placement.
package uart_bram_packer_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;

  // Bit offset of byte k inside a word; big-endian puts the first byte in the top lane.
  function automatic int lane_lsb(input int k, input int bpw, input bit big_e);
    return big_e ? BYTE_W * (bpw - 1 - k) : BYTE_W * k;
  endfunction

endpackage

// File: rtl/uart_bram_packer_if.sv
// Byte-stream input and BRAM write-port bundle of the packer.
interface uart_bram_packer_if #(
  parameter int BYTES_PER_WORD = 2,
  parameter int FIFO_DEPTH     = 16,
  parameter int ADDR_W         = 8
);
  localparam int DW = 8 * BYTES_PER_WORD;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              i_valid;
  logic [7:0]        i_data;
  logic              o_ready;
  logic              i_flush;
  logic              i_addr_clr;
  logic              o_wr_en_bram;
  logic [ADDR_W-1:0] o_addr_bram;
  logic [DW-1:0]     o_data_bram;
  logic [CW-1:0]     o_fifo_count;
  logic              o_overflow;

  modport slave (
    input  i_valid, i_data, i_flush, i_addr_clr,
    output o_ready, o_wr_en_bram, o_addr_bram, o_data_bram, o_fifo_count, o_overflow
  );

  modport master (
    output i_valid, i_data, i_flush, i_addr_clr,
    input  o_ready, o_wr_en_bram, o_addr_bram, o_data_bram, o_fifo_count, o_overflow
  );
endinterface

// File: rtl/uart_bram_packer_sync_byte_fifo.sv
// Single-clock byte FIFO with registered storage (no fall-through) and a sticky overflow flag.
module sync_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [7:0]             data_i,
  input  logic                   pop_i,
  output logic [7:0]             data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q;
  logic          push_ok, pop_ok;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign data_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // A push against a full FIFO is lost even if a pop frees a slot in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (push_i && full_o) ovf_q <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_bram_packer.sv
// Packs buffered UART bytes into BRAM words with auto-incrementing address, flush and idle padding.
module uart_bram_packer #(
  parameter int BYTES_PER_WORD = 2,
  parameter int FIFO_DEPTH     = 16,
  parameter int ADDR_W         = 8,
  parameter int BASE_ADDR      = 1,
  parameter int BIG_ENDIAN     = 1,
  parameter int IDLE_TIMEOUT   = 64
) (
  input logic               i_clk,
  input logic               i_rst,
  uart_bram_packer_if.slave bus
);
  import uart_bram_packer_pkg::*;

  localparam int DW = BYTE_W * BYTES_PER_WORD;
  localparam int LW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [LW-1:0]     LAST_LANE = LW'(BYTES_PER_WORD - 1);
  localparam logic [TW-1:0]     TMO_MAX   = TW'(IDLE_TIMEOUT);

  logic [7:0]    fifo_byte;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty, fifo_ovf, pop;

  logic [1:0]        state_q, state_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [DW-1:0]     word_q, word_d, placed, emit_word;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] nxt_q, nxt_d, addr_q, addr_d;
  logic              wr_q, wr_d, emit, tmo_hit;
  logic [DW-1:0]     data_q, data_d;

  sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .push_i     (bus.i_valid),
    .data_i     (bus.i_data),
    .pop_i      (pop),
    .data_o     (fifo_byte),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .overflow_o (fifo_ovf)
  );

  assign bus.o_ready      = ~fifo_full;
  assign bus.o_fifo_count = fifo_count;
  assign bus.o_overflow   = fifo_ovf;
  assign bus.o_wr_en_bram = wr_q;
  assign bus.o_addr_bram  = addr_q;
  assign bus.o_data_bram  = data_q;

  // The pad cycle does not consume a byte; it is picked up on return to idle.
  assign pop     = ~fifo_empty & (state_q != S_PAD);
  assign tmo_hit = (IDLE_TIMEOUT != 0) && (tmo_q == TMO_MAX);

  // Current word with the popped byte dropped into its lane; a new word starts from zero.
  always_comb begin
    placed = (state_q == S_IDLE) ? '0 : word_q;
    for (int k = 0; k < BYTES_PER_WORD; k++)
      if (lane_q == LW'(k))
        placed[lane_lsb(k, BYTES_PER_WORD, BIG_ENDIAN != 0) +: BYTE_W] = fifo_byte;
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    word_d    = word_q;
    tmo_d     = tmo_q;
    flush_d   = flush_q | bus.i_flush;
    nxt_d     = bus.i_addr_clr ? BASE_A : nxt_q;
    wr_d      = 1'b0;
    data_d    = data_q;
    addr_d    = addr_q;
    emit      = 1'b0;
    emit_word = '0;

    if (BYTES_PER_WORD == 1) begin
      if (pop) begin
        emit      = 1'b1;
        emit_word = placed;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          tmo_d = '0;
          if (pop) begin
            word_d  = placed;
            lane_d  = LW'(1);
            state_d = S_FILL;
          end
        end
        S_FILL: begin
          if (pop) begin
            tmo_d = '0;
            if (lane_q == LAST_LANE) begin
              emit      = 1'b1;
              emit_word = placed;
              lane_d    = '0;
              state_d   = S_IDLE;
            end else begin
              word_d = placed;
              lane_d = lane_q + 1'b1;
            end
          end else if (flush_q || tmo_hit) begin
            tmo_d   = '0;
            state_d = S_PAD;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_PAD: begin
          emit      = 1'b1;
          emit_word = word_q;
          lane_d    = '0;
          state_d   = S_IDLE;
          flush_d   = bus.i_flush;
        end
        default: begin
          lane_d  = '0;
          tmo_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end

    if (state_q == S_IDLE && fifo_empty) flush_d = bus.i_flush;

    // A coincident address clear still lets this write use the old address.
    if (emit) begin
      wr_d   = 1'b1;
      data_d = emit_word;
      addr_d = nxt_q;
      nxt_d  = bus.i_addr_clr ? BASE_A : nxt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      word_q  <= '0;
      tmo_q   <= '0;
      flush_q <= 1'b0;
      nxt_q   <= BASE_A;
      addr_q  <= BASE_A;
      wr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      tmo_q   <= tmo_d;
      flush_q <= flush_d;
      nxt_q   <= nxt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_uart_bram_packer.sv
// Bench for uart_bram_packer: directed cases plus a randomized byte stream against a word-level model.
module tb_uart_bram_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  uart_bram_packer_if #(.BYTES_PER_WORD(2), .FIFO_DEPTH(16), .ADDR_W(8)) ifa ();
  uart_bram_packer_if #(.BYTES_PER_WORD(4), .FIFO_DEPTH(8),  .ADDR_W(2)) ifb ();

  uart_bram_packer #(
    .BYTES_PER_WORD(2), .FIFO_DEPTH(16), .ADDR_W(8),
    .BASE_ADDR(1), .BIG_ENDIAN(1), .IDLE_TIMEOUT(64)
  ) u_a (.i_clk(clk), .i_rst(rst), .bus(ifa));

  uart_bram_packer #(
    .BYTES_PER_WORD(4), .FIFO_DEPTH(8), .ADDR_W(2),
    .BASE_ADDR(3), .BIG_ENDIAN(0), .IDLE_TIMEOUT(0)
  ) u_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

  logic       f_push = 1'b0, f_pop = 1'b0;
  logic [7:0] f_data = 8'h00, f_dout;
  logic [4:0] f_count;
  logic       f_full, f_empty, f_ovf;

  sync_byte_fifo #(.DEPTH(16)) u_f (
    .clk_i(clk), .rst_i(rst), .push_i(f_push), .data_i(f_data), .pop_i(f_pop),
    .data_o(f_dout), .count_o(f_count), .full_o(f_full), .empty_o(f_empty), .overflow_o(f_ovf)
  );

  // Captured BRAM writes.
  logic [63:0] qa_d[$], qa_a[$], qa_t[$];
  logic [63:0] qb_d[$], qb_a[$], qb_t[$];
  int   b2b = 0;
  logic prev_a = 1'b0;

  always @(negedge clk) begin
    if (ifa.o_wr_en_bram) begin
      qa_d.push_back(64'(ifa.o_data_bram));
      qa_a.push_back(64'(ifa.o_addr_bram));
      qa_t.push_back(64'(cyc));
      if (prev_a) b2b++;
    end
    prev_a = ifa.o_wr_en_bram;
    if (ifb.o_wr_en_bram) begin
      qb_d.push_back(64'(ifb.o_data_bram));
      qb_a.push_back(64'(ifb.o_addr_bram));
      qb_t.push_back(64'(cyc));
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] at(input logic [63:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return '1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    qa_d.delete(); qa_a.delete(); qa_t.delete();
    qb_d.delete(); qb_a.delete(); qb_t.delete();
  endtask

  task automatic push_a(input logic [7:0] b);
    ifa.i_valid = 1'b1;
    ifa.i_data  = b;
    tick();
    ifa.i_valid = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] b);
    ifb.i_valid = 1'b1;
    ifb.i_data  = b;
    tick();
    ifb.i_valid = 1'b0;
  endtask

  task automatic wait_a(input int n, input int lim);
    for (int i = 0; i < lim && qa_d.size() < n; i++) tick();
  endtask

  task automatic wait_b(input int n, input int lim);
    for (int i = 0; i < lim && qb_d.size() < n; i++) tick();
  endtask

  // Word-level model for the big-endian 2-byte instance: first byte is most significant.
  logic [7:0]  cur[$];
  logic [63:0] ea_d[$], ea_a[$];
  logic [7:0]  ma;

  task automatic m_emit();
    logic [63:0] w;
    w = 64'd0;
    for (int k = 0; k < 2; k++) w = (w << 8) | 64'((k < cur.size()) ? cur[k] : 8'h00);
    ea_d.push_back(w);
    ea_a.push_back(64'(ma));
    ma = ma + 8'd1;
    cur.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, want completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t, w;
    logic [7:0]  sb[20];
    logic [7:0]  bb[8];
    logic [7:0]  b;
    int          r, n0;

    ifa.i_valid = 0; ifa.i_data = 0; ifa.i_flush = 0; ifa.i_addr_clr = 0;
    ifb.i_valid = 0; ifb.i_data = 0; ifb.i_flush = 0; ifb.i_addr_clr = 0;

    do_reset();
    chk("rst_wr",    64'(ifa.o_wr_en_bram), 64'd0);
    chk("rst_addr",  64'(ifa.o_addr_bram),  64'd1);
    chk("rst_data",  64'(ifa.o_data_bram),  64'd0);
    chk("rst_cnt",   64'(ifa.o_fifo_count), 64'd0);
    chk("rst_ovf",   64'(ifa.o_overflow),   64'd0);
    chk("rst_rdy",   64'(ifa.o_ready),      64'd1);
    chk("rst_b_addr", 64'(ifb.o_addr_bram), 64'd3);

    // Two-byte word and its latency from the last push.
    push_a(8'hA1);
    t = 64'(cyc);
    push_a(8'hB2);
    wait_a(1, 10);
    chk("a1b2_data", at(qa_d, 0), 64'hA1B2);
    chk("a1b2_addr", at(qa_a, 0), 64'd1);
    chk("a1b2_lat",  at(qa_t, 0), t + 64'd2);

    // Lone byte padded after the idle timeout.
    t = 64'(cyc);
    push_a(8'h5C);
    wait_a(2, 120);
    chk("tmo_data", at(qa_d, 1), 64'h5C00);
    chk("tmo_addr", at(qa_a, 1), 64'd2);
    chk("tmo_delay", 64'((at(qa_t, 1) - t >= 64) && (at(qa_t, 1) - t <= 80)), 64'd1);

    // Reset with a partial word in flight.
    push_a(8'hC3);
    chk("mid_cnt_pre", 64'(ifa.o_fifo_count), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n0 = qa_d.size();
    idle(100);
    chk("mid_nowr", 64'(qa_d.size()), 64'(n0));
    chk("mid_addr", 64'(ifa.o_addr_bram), 64'd1);
    chk("mid_cnt",  64'(ifa.o_fifo_count), 64'd0);

    // Back-to-back stream of 20 bytes.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      sb[k] = 8'($urandom);
      push_a(sb[k]);
    end
    wait_a(10, 40);
    idle(5);
    chk("str_cnt", 64'(qa_d.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      chk("str_data", at(qa_d, i), {48'd0, sb[2*i], sb[2*i+1]});
      chk("str_addr", at(qa_a, i), 64'(i + 1));
    end
    chk("str_ovf", 64'(ifa.o_overflow), 64'd0);

    // Random bursts: short gaps keep words together, long gaps (with or without flush) pad them.
    do_reset();
    cur.delete(); ea_d.delete(); ea_a.delete();
    ma = 8'd1;
    for (int k = 0; k < 60; k++) begin
      b = 8'($urandom);
      push_a(b);
      cur.push_back(b);
      if (cur.size() == 2) m_emit();
      r = $urandom_range(0, 9);
      if (r == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          ifa.i_flush = 1'b1;
          tick();
          ifa.i_flush = 1'b0;
          idle(99);
        end else begin
          idle(100);
        end
        if (cur.size() > 0) m_emit();
      end else if (r < 4) begin
        idle(r);
      end
    end
    idle(100);
    if (cur.size() > 0) m_emit();
    chk("rnd_cnt", 64'(qa_d.size()), 64'(ea_d.size()));
    for (int i = 0; i < ea_d.size(); i++) begin
      chk("rnd_data", at(qa_d, i), ea_d[i]);
      chk("rnd_addr", at(qa_a, i), ea_a[i]);
    end
    chk("rnd_ovf", 64'(ifa.o_overflow), 64'd0);
    chk("no_b2b_wr", 64'(b2b), 64'd0);

    // Byte FIFO with pops held off: overflow, drop on full even with a pop, and ordering.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      f_push = 1'b1;
      f_data = 8'(k * 7 + 3);
      tick();
    end
    f_push = 1'b0;
    chk("f_cnt_full", 64'(f_count), 64'd16);
    chk("f_full",     64'(f_full),  64'd1);
    chk("f_ovf",      64'(f_ovf),   64'd1);
    f_push = 1'b1;
    f_pop  = 1'b1;
    f_data = 8'hEE;
    chk("f_head", 64'(f_dout), 64'd3);
    tick();
    f_push = 1'b0;
    chk("f_cnt_drop", 64'(f_count), 64'd15);
    for (int k = 1; k < 16; k++) begin
      chk("f_order", 64'(f_dout), 64'(8'(k * 7 + 3)));
      tick();
    end
    f_pop = 1'b0;
    chk("f_empty", 64'(f_empty), 64'd1);
    chk("f_cnt_end", 64'(f_count), 64'd0);

    // 4-byte little-endian instance with 2-bit address starting at 3.
    do_reset();
    push_b(8'h11); push_b(8'h22); push_b(8'h33); push_b(8'h44);
    wait_b(1, 10);
    chk("b_le_data", at(qb_d, 0), 64'h44332211);
    chk("b_le_addr", at(qb_a, 0), 64'd3);
    for (int k = 0; k < 8; k++) begin
      bb[k] = 8'($urandom);
      push_b(bb[k]);
    end
    wait_b(3, 20);
    for (int i = 0; i < 2; i++) begin
      w = 64'd0;
      for (int j = 0; j < 4; j++) w = w + (64'(bb[4*i+j]) << (8 * j));
      chk("b_wrap_data", at(qb_d, i + 1), w);
      chk("b_wrap_addr", at(qb_a, i + 1), 64'(i));
    end

    ifb.i_addr_clr = 1'b1;
    tick();
    ifb.i_addr_clr = 1'b0;
    push_b(8'h01); push_b(8'h02); push_b(8'h03); push_b(8'h04);
    wait_b(4, 10);
    chk("b_clr_addr", at(qb_a, 3), 64'd3);
    chk("b_clr_data", at(qb_d, 3), 64'h04030201);

    // Timeout disabled: a partial word waits for an explicit flush.
    push_b(8'hAB);
    idle(100);
    chk("b_no_tmo", 64'(qb_d.size()), 64'd4);
    ifb.i_flush = 1'b1;
    tick();
    ifb.i_flush = 1'b0;
    wait_b(5, 10);
    chk("b_flush_data", at(qb_d, 4), 64'h000000AB);
    chk("b_flush_addr", at(qb_a, 4), 64'd0);

    // Address clear in the same cycle as a write.
    push_b(8'h05); push_b(8'h06); push_b(8'h07);
    t = 64'(cyc);
    push_b(8'h08);
    tick();
    ifb.i_addr_clr = 1'b1;
    tick();
    ifb.i_addr_clr = 1'b0;
    wait_b(6, 10);
    chk("b_coin_time", at(qb_t, 5), t + 64'd2);
    chk("b_coin_addr", at(qb_a, 5), 64'd1);
    chk("b_coin_data", at(qb_d, 5), 64'h08070605);
    push_b(8'h09); push_b(8'h0A); push_b(8'h0B); push_b(8'h0C);
    wait_b(7, 10);
    chk("b_after_clr", at(qb_a, 6), 64'd3);
    chk("b_ovf", 64'(ifb.o_overflow), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
